// File: rtl/prefetch_pace.sv
// Output pacing counter: loads a hold length on each accepted word and counts it down,
// reporting busy while any hold cycles remain.
module prefetch_pace #(
    parameter int unsigned TW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          busy
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/prefetch_queue.sv
// Multi-entry show-ahead prefetch queue between two get/empty ports, with fill level,
// synchronous flush and per-word output pacing.
module prefetch_queue #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 2,
    parameter int unsigned TW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic [W-1:0]  in,
    output logic          get_i,
    input  logic          empty_i,
    output logic [W-1:0]  out,
    input  logic          get_o,
    output logic          empty_o,
    output logic [AW:0]   level,
    input  logic [TW-1:0] hold
);

    localparam int unsigned Depth = 2 ** AW;
    localparam logic [AW:0] FullLevel = (AW + 1)'(Depth);

    logic [W-1:0]  mem_q [Depth];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   level_q;
    logic          full;
    logic          busy;
    logic          acc;

    // Fetch depends only on registered state, never on get_o.
    assign full    = (level_q == FullLevel);
    assign get_i   = !empty_i && !full && !flush && !reset;
    assign empty_o = (level_q == '0) || busy;
    assign acc     = get_o && !empty_o;
    assign out     = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clock) begin
        if (get_i) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (get_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (acc) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({get_i, acc})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    prefetch_pace #(
        .TW(TW)
    ) u_pace (
        .clock(clock),
        .reset(reset),
        .clear(flush),
        .load (acc),
        .value(hold),
        .busy (busy)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: a queue-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_prefetch_queue;

    localparam int W = 8;
    localparam int AW = 2;
    localparam int TW = 3;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic [W-1:0]  in_w;
    logic          get_i;
    logic          empty_i;
    logic [W-1:0]  out;
    logic          get_o;
    logic          empty_o;
    logic [AW:0]   level;
    logic [TW-1:0] hold;

    int tests = 0;
    int fails = 0;

    // Source: a word list consumed whenever the DUT pops.
    logic [7:0] src_mem [16];
    int src_len = 0;
    int src_base = 0;
    int pops = 0;
    int src_idx;
    assign src_idx = pops - src_base;
    assign empty_i = (src_idx >= src_len);
    assign in_w    = empty_i ? 8'h00 : src_mem[src_idx[3:0]];

    // Model state
    logic [7:0] m_q[$];
    int m_hcnt = 0;
    bit m_ok = 0;

    always #5 clock = ~clock;

    prefetch_queue #(
        .W (W),
        .AW(AW),
        .TW(TW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .in     (in_w),
        .get_i  (get_i),
        .empty_i(empty_i),
        .out    (out),
        .get_o  (get_o),
        .empty_o(empty_o),
        .level  (level),
        .hold   (hold)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(posedge clock) begin
        bit m_empty, m_get, m_acc;
        m_empty = (m_q.size() == 0) || (m_hcnt != 0);
        m_get   = !empty_i && (m_q.size() < DEPTH) && !flush && !reset;
        if (reset || flush) begin
            m_q.delete();
            m_hcnt = 0;
            if (reset) m_ok = 1;
        end else begin
            m_acc = get_o && !m_empty;
            if (m_acc) begin
                void'(m_q.pop_front());
                m_hcnt = int'(hold);
            end else if (m_hcnt != 0) begin
                m_hcnt--;
            end
            if (m_get) m_q.push_back(in_w);
        end
        if (get_i) pops <= pops + 1;
    end

    always @(negedge clock) begin
        bit e_empty, e_get;
        if (m_ok) begin
            e_empty = (m_q.size() == 0) || (m_hcnt != 0);
            e_get   = !empty_i && (m_q.size() < DEPTH) && !flush && !reset;
            chk("cyc_get_i", 32'(get_i), 32'(e_get));
            chk("cyc_empty_o", 32'(empty_o), 32'(e_empty));
            chk("cyc_level", 32'(level), 32'(m_q.size()));
            if (!e_empty) chk("cyc_out", 32'(out), 32'(m_q[0]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic look();
        @(negedge clock);
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) src_mem[i] = s[i];
        src_len  = s.len();
        src_base = pops;
    endtask

    task automatic load_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) src_mem[i] = base + 8'(i);
        src_len  = n;
        src_base = pops;
    endtask

    logic [7:0] got[$];
    string hello = "hello\n";
    int pulses;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        get_o = 1'b0;
        hold  = '0;
        tick();
        tick();

        // Fill from reset
        load_str(hello);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            look();
            if (get_i) pulses++;
            tick();
        end
        look();
        chk("fill_pulses", 32'(pulses), 32'd4);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_out", 32'(out), 32'h68);
        chk("fill_empty_o", 32'(empty_o), 32'd0);
        chk("fill_get_i", 32'(get_i), 32'd0);
        tick();

        // Drain with hold = 0
        get_o = 1'b1;
        got.delete();
        for (int i = 0; i < 9; i++) begin
            look();
            if (i == 0) chk("drain_get_i0", 32'(get_i), 32'd0);
            if (i == 1) chk("drain_get_i1", 32'(get_i), 32'd1);
            if (!empty_o) got.push_back(out);
            tick();
        end
        look();
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_empty_o", 32'(empty_o), 32'd1);
        chk("drain_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("drain_word", 32'(got[i]), 32'(hello[i]));
        tick();

        // Pacing
        get_o = 1'b0;
        load_str(hello);
        for (int i = 0; i < 6; i++) tick();
        look();
        chk("pace_level_full", 32'(level), 32'd4);
        tick();
        get_o = 1'b1;
        hold  = 3'd3;
        look();
        chk("pace_out_h", 32'(out), 32'h68);
        tick();
        hold = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            look();
            chk("pace_masked", 32'(empty_o), 32'd1);
            if (k == 3) chk("pace_level_back", 32'(level), 32'd4);
            tick();
        end
        look();
        chk("pace_empty_o_4th", 32'(empty_o), 32'd0);
        chk("pace_out_e", 32'(out), 32'h65);
        tick();
        get_o = 1'b0;

        // Pointer wrap: 10 words, get_o toggling
        flush = 1'b1;
        load_seq(8'hA0, 10);
        tick();
        flush = 1'b0;
        got.delete();
        for (int i = 0; i < 40; i++) begin
            get_o = i[0];
            look();
            if (get_o && !empty_o) got.push_back(out);
            tick();
        end
        get_o = 1'b0;
        chk("wrap_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("wrap_word", 32'(got[i]), 32'hA0 + 32'(i));

        // Flush at level 3 with a simultaneous pop
        flush = 1'b1;
        load_str("ABCDEFG");
        tick();
        flush = 1'b0;
        tick();
        tick();
        tick();
        flush = 1'b1;
        get_o = 1'b1;
        look();
        chk("flush_level_pre", 32'(level), 32'd3);
        chk("flush_get_i", 32'(get_i), 32'd0);
        tick();
        flush = 1'b0;
        get_o = 1'b0;
        look();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_empty_o", 32'(empty_o), 32'd1);
        tick();
        look();
        chk("flush_refetch_level", 32'(level), 32'd1);
        chk("flush_refetch_out", 32'(out), 32'h44);
        tick();

        // Reset mid-hold and mid-fill
        flush = 1'b1;
        load_seq(8'h10, 12);
        tick();
        flush = 1'b0;
        tick();
        tick();
        get_o = 1'b1;
        hold  = 3'd3;
        look();
        chk("rst_pre_level", 32'(level), 32'd2);
        tick();
        get_o = 1'b0;
        hold  = 3'd0;
        look();
        chk("rst_hold_active", 32'(empty_o), 32'd1);
        tick();
        reset = 1'b1;
        look();
        chk("rst_get_i_high", 32'(get_i), 32'd0);
        chk("rst_level_pre", 32'(level), 32'd3);
        tick();
        look();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty_o", 32'(empty_o), 32'd1);
        chk("rst_get_i", 32'(get_i), 32'd0);
        tick();
        reset = 1'b0;
        look();
        chk("rst_resume_get_i", 32'(get_i), 32'd1);
        tick();
        look();
        chk("rst_resume_level", 32'(level), 32'd1);
        chk("rst_resume_empty_o", 32'(empty_o), 32'd0);
        chk("rst_resume_out", 32'(out), 32'h14);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
